// File: rtl/tx_iq_fifo.sv
// tx_iq_fifo: elastic I/Q buffer from the bus interface to the TX interpolator,
// with prefill gating, round/saturate on read, and overflow/underflow status.
module tx_iq_fifo #(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8,
    parameter int SHIFT   = 16,
    parameter int OUT_W   = 16
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       tx,
    input  logic [31:0]                in_i,
    input  logic [31:0]                in_q,
    input  logic                       in_valid,
    input  logic                       sample_req,
    output logic signed [OUT_W-1:0]    out_i,
    output logic signed [OUT_W-1:0]    out_q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                underflow_cnt,
    output logic                       running
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] PRE  = LW'(PREFILL);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic signed [32:0] RND  = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state, state_n;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            in_valid_d, wr_edge, full, rd, wr, ovf_set, zero_req, uf;

    // Round half up, then clamp to the signed output range.
    function automatic logic signed [OUT_W-1:0] scale(input logic [31:0] x);
        logic signed [32:0] s;
        s = ($signed({x[31], x}) + RND) >>> SHIFT;
        return s > MAXV ? OUT_W'(MAXV) : s < MINV ? OUT_W'(MINV) : OUT_W'(s);
    endfunction

    assign wr_edge = in_valid & ~in_valid_d;
    assign full    = level == FULL;
    assign running = state == RUN;

    always_comb begin
        state_n  = state;
        rd       = 1'b0;
        zero_req = 1'b0;
        uf       = 1'b0;
        if (!tx)
            state_n = IDLE;
        else
            case (state)
                IDLE:  state_n = PRIME;
                PRIME: begin
                    zero_req = sample_req;
                    if (level >= PRE) state_n = RUN;
                end
                RUN: if (sample_req) begin
                    if (level != '0) rd = 1'b1;
                    else begin
                        uf       = 1'b1;
                        zero_req = 1'b1;
                        state_n  = PRIME;
                    end
                end
                default: state_n = IDLE;
            endcase
        wr      = tx && state != IDLE && wr_edge && (!full || rd);
        ovf_set = tx && state != IDLE && wr_edge && full && !rd;
    end

    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_n;

    always_ff @(posedge clk_in)
        if (wr) mem[wr_ptr] <= {in_i, in_q};

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            in_valid_d    <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            out_i         <= '0;
            out_q         <= '0;
            out_valid     <= 1'b0;
            overflow      <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            in_valid_d <= in_valid;
            if (!tx) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level         <= '0;
                out_i         <= '0;
                out_q         <= '0;
                out_valid     <= 1'b0;
                overflow      <= 1'b0;
                underflow_cnt <= '0;
            end else begin
                wr_ptr        <= wr_ptr + AW'(wr);
                rd_ptr        <= rd_ptr + AW'(rd);
                level         <= level + LW'(wr) - LW'(rd);
                out_valid     <= rd | zero_req;
                out_i         <= rd ? scale(mem[rd_ptr][63:32]) : zero_req ? '0 : out_i;
                out_q         <= rd ? scale(mem[rd_ptr][31:0]) : zero_req ? '0 : out_q;
                overflow      <= overflow | ovf_set;
                underflow_cnt <= (uf && underflow_cnt != 16'hFFFF) ? underflow_cnt + 16'd1 : underflow_cnt;
            end
        end
    end
endmodule

// File: tb/tb_tx_iq_fifo.sv
// tb_tx_iq_fifo: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_tx_iq_fifo;
    logic               clk_in = 1'b0, reset_n = 1'b0, tx = 1'b0;
    logic [31:0]        in_i = '0, in_q = '0;
    logic               in_valid = 1'b0, sample_req = 1'b0;
    logic signed [15:0] out_i, out_q;
    logic               out_valid, overflow, running;
    logic [4:0]         level;
    logic [15:0]        underflow_cnt;

    typedef struct {logic [15:0] i; logic [15:0] q; int c;} exp_t;
    exp_t exp_q[$];
    int   total = 0, bad = 0, cyc = 0;

    tx_iq_fifo dut (
        .clk_in(clk_in), .reset_n(reset_n), .tx(tx), .in_i(in_i), .in_q(in_q),
        .in_valid(in_valid), .sample_req(sample_req), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .level(level), .overflow(overflow),
        .underflow_cnt(underflow_cnt), .running(running)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        exp_t e;
        if (reset_n && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sample: out_valid with nothing requested, got i=%0d q=%0d", out_i, out_q);
            end else begin
                e = exp_q.pop_front();
                if (out_i !== e.i || out_q !== e.q || cyc != e.c + 1) begin
                    bad++;
                    $display("FAIL sample: got i=%0d q=%0d cyc=%0d, want i=%0d q=%0d cyc=%0d",
                             out_i, out_q, cyc, $signed(e.i), $signed(e.q), e.c + 1);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic write(logic [31:0] i, logic [31:0] q);
        in_i = i;
        in_q = q;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic req(int ei, int eq);
        sample_req = 1'b1;
        exp_q.push_back('{16'(ei), 16'(eq), cyc});
        tick();
        sample_req = 1'b0;
        tick();
    endtask

    initial begin
        tick(3);
        check("reset_level", 32'(level), 0);
        check("reset_running", 32'(running), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_overflow", 32'(overflow), 0);
        check("reset_underflow", 32'(underflow_cnt), 0);
        check("reset_out_i", 32'(out_i), 0);
        reset_n = 1'b1;
        tick();
        tx = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) check("running_before_prefill", 32'(running), 0);
            write(k * 32'h10000, -k * 32'h10000);
        end
        check("prefill_level", 32'(level), 8);
        check("prefill_running", 32'(running), 1);
        for (int k = 1; k <= 8; k++) req(k, -k);
        check("drained_level", 32'(level), 0);

        in_i = 32'h30000;
        in_q = 32'h50000;
        in_valid = 1'b1;
        tick(20);
        in_valid = 1'b0;
        tick();
        check("held_valid_level", 32'(level), 1);

        write(32'h00008000, 32'h00000000);
        write(32'hFFFF7FFF, 32'h00000000);
        write(32'h7FFFFFFF, 32'h80000000);
        write(32'h80000000, 32'h7FFFFFFF);
        check("round_level", 32'(level), 5);
        req(3, 5);
        req(1, 0);
        req(-1, 0);
        req(32767, -32768);
        req(-32768, 32767);

        for (int k = 1; k <= 16; k++) write(k * 32'h10000, 0);
        check("full_level", 32'(level), 16);
        check("overflow_before", 32'(overflow), 0);
        write(32'h630000, 0);
        check("overflow_level", 32'(level), 16);
        check("overflow_set", 32'(overflow), 1);
        in_i = 32'h640000;
        in_q = 0;
        in_valid = 1'b1;
        req(1, 0);
        in_valid = 1'b0;
        check("full_rw_level", 32'(level), 16);
        check("full_rw_overflow", 32'(overflow), 1);
        for (int k = 2; k <= 16; k++) req(k, 0);
        req(100, 0);
        check("empty_running", 32'(running), 1);

        req(0, 0);
        check("underflow_cnt", 32'(underflow_cnt), 1);
        check("underflow_running", 32'(running), 0);
        for (int k = 1; k <= 8; k++) write(k * 32'h10000, 0);
        check("reprime_running", 32'(running), 1);
        req(1, 0);
        req(2, 0);
        req(3, 0);
        check("pre_flush_level", 32'(level), 5);
        tx = 1'b0;
        tick();
        check("flush_level", 32'(level), 0);
        check("flush_running", 32'(running), 0);
        check("flush_overflow", 32'(overflow), 0);
        check("flush_underflow", 32'(underflow_cnt), 0);
        check("flush_out_i", 32'(out_i), 0);

        tx = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) write(k * 32'h10000, 32'h20000);
        req(1, 2);
        check("pre_reset_level", 32'(level), 8);
        in_i = 32'h70000;
        in_valid = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("async_level", 32'(level), 0);
        check("async_out_i", 32'(out_i), 0);
        check("async_out_q", 32'(out_q), 0);
        check("async_running", 32'(running), 0);
        check("async_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(2);
        check("post_reset_level", 32'(level), 0);
        check("pending_samples", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
